imem_program_loader: RTL and testbench

//  Boot-time loader that sits upstream of the single-cycle MIPS32 core.

---
 rtl/imem_program_loader_pkg.sv | 21 ++
 rtl/loader_word_packer.sv | 41 ++++
 rtl/imem_program_loader.sv | 151 +++++++++++++++
 tb/tb_imem_program_loader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the boot loader: frame-state encoding and LEN field width.
// Also imported by core-level benches to decode the loader status.
package imem_program_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } load_state_t;

  function automatic logic is_busy(load_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs big-endian bytes into 32-bit words and keeps the running XOR of frame bytes.
// word_ready/packed_word are combinational and valid in the cycle the 4th byte is shifted.
module loader_word_packer (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        clear,
  input  logic        shift,
  input  logic        acc,
  input  logic [7:0]  byte_in,
  output logic        word_ready,
  output logic [31:0] packed_word,
  output logic [7:0]  csum
);

  logic [23:0] shreg;
  logic [1:0]  cnt;

  assign word_ready  = shift && (cnt == 2'd3);
  assign packed_word = {shreg, byte_in};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shreg <= '0;
      cnt   <= '0;
      csum  <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
      csum  <= '0;
    end else begin
      if (shift) begin
        shreg <= {shreg[15:0], byte_in};
        cnt   <= cnt + 2'd1;
      end
      if (acc) begin
        csum <= csum ^ byte_in;
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// Boot-time loader: receives a LEN/DATA/CSUM byte frame, writes instruction memory from
// address 0 and holds the core PC clear until a load ends with a good checksum.
module imem_program_loader
  import imem_program_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_clr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are both 1;
  // the source holds rx_data/rx_valid until then. rx_ready is registered.

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W+1)'(1) << ADDR_W;

  load_state_t      state_q;
  logic [7:0]       len_hi;
  logic [LEN_W-1:0] len_words;
  logic [CNT_W-1:0] word_cnt;

  logic             xfer;
  logic             can_start;
  logic [LEN_W-1:0] len_next;
  logic             too_long;
  logic             last_word;
  logic             word_ready;
  logic [31:0]      packed_word;
  logic [7:0]       csum;

  assign xfer      = rx_valid && rx_ready;
  assign can_start = start && ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ERR));
  assign len_next  = {len_hi, rx_data};
  assign too_long  = {1'b0, len_next} > MAX_WORDS;
  assign last_word = (LEN_W'(word_cnt) + LEN_W'(1)) == len_words;
  assign state     = state_q;

  loader_word_packer u_packer (
    .clk         (clk),
    .clr_n       (clr_n),
    .clear       (can_start),
    .shift       (xfer && (state_q == ST_DATA)),
    .acc         (xfer && ((state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) || (state_q == ST_DATA))),
    .byte_in     (rx_data),
    .word_ready  (word_ready),
    .packed_word (packed_word),
    .csum        (csum)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      len_hi     <= '0;
      len_words  <= '0;
      word_cnt   <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_clr    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_q)
        ST_IDLE, ST_RUN, ST_ERR: begin
          if (can_start) begin
            state_q  <= ST_LEN_HI;
            word_cnt <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_clr  <= 1'b1;
            busy     <= 1'b1;
            rx_ready <= 1'b1;
          end
        end
        ST_LEN_HI: begin
          if (xfer) begin
            len_hi  <= rx_data;
            state_q <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (xfer) begin
            len_words <= len_next;
            if (len_next == '0) begin
              state_q <= ST_CSUM;
            end else if (too_long) begin
              state_q  <= ST_ERR;
              err      <= 1'b1;
              busy     <= 1'b0;
              rx_ready <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          rx_ready <= 1'b1;
          // Completing a word closes rx_ready for the write cycle that follows.
          if (word_ready) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt[ADDR_W-1:0];
            imem_wdata <= packed_word;
            word_cnt   <= word_cnt + CNT_W'(1);
            rx_ready   <= 1'b0;
            if (last_word) begin
              state_q <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          rx_ready <= 1'b1;
          if (xfer) begin
            busy     <= 1'b0;
            rx_ready <= 1'b0;
            if (rx_data == csum) begin
              state_q <= ST_RUN;
              done    <= 1'b1;
              cpu_clr <= 1'b0;
            end else begin
              state_q <= ST_ERR;
              err     <= 1'b1;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
          cpu_clr  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: frame loads, checksum/length errors,
// gapped valid, ignored start and asynchronous reset mid-load.
module tb_imem_program_loader;
  import imem_program_loader_pkg::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              clr_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_clr;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        state;

  int total = 0;
  int bad = 0;
  int timeouts = 0;
  int ready_in_write = 0;

  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];
  logic [31:0]       exp_q[$];
  logic [7:0]        frame[$];

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_clr    (cpu_clr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .state      (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      if (rx_ready) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    rx_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int tries;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    tries = 0;
    while (!rx_ready && tries < 50) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 50) timeouts++;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gapped);
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], gapped ? ((i % 2 == 0) ? 0 : int'($urandom_range(1, 3))) : 0);
    end
  endtask

  task automatic set_prog1(input logic [7:0] cs);
    frame = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'hc8, 8'hfc, 8'h00, 8'h00, 8'h00};
    frame.push_back(cs);
    exp_q = '{32'h200100c8, 32'hfc000000};
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_we_count"}, wr_data_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_data_q.size(); i++) begin
      check({tag, "_addr"}, 32'(wr_addr_q[i]), i);
      check({tag, "_data"}, wr_data_q[i], exp_q[i]);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_clr", cpu_clr, 1);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_we", imem_we, 0);
    check("rst_state", state, ST_IDLE);
    clr_n = 1'b1;
    @(negedge clk);

    // 1: good 2-word program
    clear_log();
    set_prog1(8'h17);
    pulse_start();
    check("t1_busy", busy, 1);
    check("t1_state", state, ST_LEN_HI);
    for (int i = 0; i < frame.size() - 1; i++) send_byte(frame[i], 0);
    check("t1_cpu_clr_pre", cpu_clr, 1);
    check("t1_state_csum", state, ST_CSUM);
    send_byte(frame[frame.size()-1], 0);
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_cpu_clr", cpu_clr, 0);
    check("t1_busy_end", busy, 0);
    check("t1_state_run", state, ST_RUN);
    check_writes("t1");

    // 2: bad checksum, restart straight from RUN
    clear_log();
    set_prog1(8'h18);
    pulse_start();
    check("t2_done_cleared", done, 0);
    check("t2_cpu_clr_rehold", cpu_clr, 1);
    send_frame(1'b0);
    check("t2_err", err, 1);
    check("t2_done", done, 0);
    check("t2_cpu_clr", cpu_clr, 1);
    check("t2_state", state, ST_ERR);
    check_writes("t2");

    // 3: length 1025 overflows
    clear_log();
    pulse_start();
    check("t3_err_cleared", err, 0);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    check("t3_state", state, ST_ERR);
    check("t3_err", err, 1);
    check("t3_rx_ready", rx_ready, 0);
    rx_data = 8'h55;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_rx_ready_hold", rx_ready, 0);
    rx_valid = 1'b0;
    check("t3_we_count", wr_data_q.size(), 0);

    // length 1024 is the largest legal load
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    check("t3b_state", state, ST_DATA);
    check("t3b_err", err, 0);
    do_reset();

    // 4: empty program
    clear_log();
    exp_q.delete();
    frame = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_frame(1'b0);
    check("t4_state", state, ST_RUN);
    check("t4_done", done, 1);
    check("t4_cpu_clr", cpu_clr, 0);
    check_writes("t4");

    // 5: gapped and back-to-back valid
    clear_log();
    ready_in_write = 0;
    set_prog1(8'h17);
    pulse_start();
    send_frame(1'b1);
    check("t5_done", done, 1);
    check("t5_ready_in_write", ready_in_write, 0);
    check_writes("t5");

    // 6: start ignored mid-DATA, then async reset after word 0
    clear_log();
    set_prog1(8'h17);
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    pulse_start();
    check("t6_ignore_state", state, ST_DATA);
    check("t6_ignore_busy", busy, 1);
    send_byte(frame[4], 0);
    send_byte(frame[5], 0);
    @(negedge clk);
    check("t6_word0_count", wr_data_q.size(), 1);
    check("t6_word0", wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, 32'h200100c8);
    clr_n = 1'b0;
    #1;
    check("t6_rst_cpu_clr", cpu_clr, 1);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_state", state, ST_IDLE);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_frame(1'b0);
    check("t6_done", done, 1);
    check("t6_cpu_clr", cpu_clr, 0);
    check_writes("t6");

    check("timeouts", timeouts, 0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
